// File: rtl/divide_scheduler.sv
// divide_scheduler: shares a single start/busy/fin divider among NUM_REQ
// requesters with round-robin arbitration. For each accepted request the
// operands are latched, the divider is started once, its quotient is captured
// on fin and returned tagged with the requester id. Divide-by-zero is answered
// locally without starting the divider, and a stuck divider is abandoned after
// TIMEOUT wait cycles.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   req_valid/ready     per-lane request handshake (ready is one-hot or zero)
//   req_dividend/divisor packed lane operands, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   rsp_valid/ready     response handshake
//   rsp_id              lane the response belongs to
//   rsp_quotient        quotient (zero on divide-by-zero or timeout)
//   rsp_status          00 ok, 01 divide-by-zero, 10 timeout
//   div_start           one-cycle start pulse to the shared divider
//   div_dividend/divisor operands to the divider, stable through ISSUE and WAIT
//   div_busy, div_fin   divider status; quotient is valid while fin is high
//   div_quotient        divider result
module divide_scheduler #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_dividend,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_divisor,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [DATA_SIZE-1:0]           rsp_quotient,
  output logic [1:0]                     rsp_status,
  output logic                           div_start,
  output logic [DATA_SIZE-1:0]           div_dividend,
  output logic [DATA_SIZE-1:0]           div_divisor,
  input  logic                           div_busy,
  input  logic                           div_fin,
  input  logic [DATA_SIZE-1:0]           div_quotient
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [ID_W-1:0]  LAST_LANE = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DIV0    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 state,        state_n;
  logic [ID_W-1:0]        rr_ptr,       rr_ptr_n;
  logic [CNT_W-1:0]       wait_cnt,     wait_cnt_n;
  logic [DATA_SIZE-1:0]   op_dividend,  op_dividend_n;
  logic [DATA_SIZE-1:0]   op_divisor,   op_divisor_n;
  logic [ID_W-1:0]        resp_id,      resp_id_n;
  logic [DATA_SIZE-1:0]   resp_quot,    resp_quot_n;
  logic [1:0]             resp_stat,    resp_stat_n;

  logic                   grant_found;
  logic [ID_W-1:0]        grant;
  logic [DATA_SIZE-1:0]   sel_dividend;
  logic [DATA_SIZE-1:0]   sel_divisor;

  // Round-robin pick: lowest valid lane at or above rr_ptr, else lowest lane overall.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!grant_found && req_valid[j] && (ID_W'(j) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant       = ID_W'(j);
      end
    end
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant       = ID_W'(j);
      end
    end
  end

  // Operand mux for the granted lane.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (ID_W'(j) == grant) begin
        sel_dividend = req_dividend[j*DATA_SIZE +: DATA_SIZE];
        sel_divisor  = req_divisor[j*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      op_dividend <= '0;
      op_divisor  <= '0;
      resp_id     <= '0;
      resp_quot   <= '0;
      resp_stat   <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      wait_cnt    <= wait_cnt_n;
      op_dividend <= op_dividend_n;
      op_divisor  <= op_divisor_n;
      resp_id     <= resp_id_n;
      resp_quot   <= resp_quot_n;
      resp_stat   <= resp_stat_n;
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    wait_cnt_n    = wait_cnt;
    op_dividend_n = op_dividend;
    op_divisor_n  = op_divisor;
    resp_id_n     = resp_id;
    resp_quot_n   = resp_quot;
    resp_stat_n   = resp_stat;
    req_ready     = '0;
    div_start     = 1'b0;

    case (state)
      S_IDLE: begin
        if (grant_found) begin
          req_ready     = NUM_REQ'(1) << grant;
          op_dividend_n = sel_dividend;
          op_divisor_n  = sel_divisor;
          resp_id_n     = grant;
          rr_ptr_n      = (grant == LAST_LANE) ? '0 : grant + ID_W'(1);
          // Zero divisor is answered here; the divider never sees it.
          if (sel_divisor == '0) begin
            resp_quot_n = '0;
            resp_stat_n = ST_DIV0;
            state_n     = S_RESP;
          end else begin
            state_n     = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (!div_busy) begin
          div_start  = 1'b1;
          wait_cnt_n = '0;
          state_n    = S_WAIT;
        end
      end

      S_WAIT: begin
        // fin wins over a timeout that would expire in the same cycle.
        if (div_fin) begin
          resp_quot_n = div_quotient;
          resp_stat_n = ST_OK;
          state_n     = S_RESP;
        end else if (wait_cnt == CNT_LAST) begin
          resp_quot_n = '0;
          resp_stat_n = ST_TIMEOUT;
          state_n     = S_RESP;
        end else begin
          wait_cnt_n  = wait_cnt + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Response and divider operand outputs are zero outside the states that own them.
  always_comb begin
    rsp_valid    = (state == S_RESP);
    rsp_id       = rsp_valid ? resp_id   : '0;
    rsp_quotient = rsp_valid ? resp_quot : '0;
    rsp_status   = rsp_valid ? resp_stat : '0;
    div_dividend = ((state == S_ISSUE) || (state == S_WAIT)) ? op_dividend : '0;
    div_divisor  = ((state == S_ISSUE) || (state == S_WAIT)) ? op_divisor  : '0;
  end

endmodule

// File: tb/tb_divide_scheduler.sv
module tb_divide_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_dividend = '0;
  logic [NR*DW-1:0]  req_divisor = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_quotient;
  logic [1:0]        rsp_status;
  logic              div_start;
  logic [DW-1:0]     div_dividend;
  logic [DW-1:0]     div_divisor;
  logic              div_busy;
  logic              div_fin;
  logic [DW-1:0]     div_quotient;

  divide_scheduler #(
    .DATA_SIZE(DW), .NUM_REQ(NR), .ID_W(IW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient), .rsp_status(rsp_status),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_fin(div_fin), .div_quotient(div_quotient)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Divider model: fin fin_k cycles after start, busy meanwhile.
  int          fin_k = 3;
  bit          never_fin = 1'b0;
  bit          force_busy = 1'b0;
  int          m_cnt = 0;
  logic [DW-1:0] m_q = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_cnt <= 0;
      m_q   <= '0;
    end else if (div_start && !never_fin && (div_divisor != '0)) begin
      m_cnt <= fin_k;
      m_q   <= $signed(div_dividend) / $signed(div_divisor);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign div_fin      = (m_cnt == 1);
  assign div_busy     = (m_cnt > 0) || force_busy;
  assign div_quotient = div_fin ? m_q : 32'hDEAD_BEEF;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [127:0] all_outputs();
    return {req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_status,
            div_start, div_dividend, div_divisor};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One request on one lane; returns at the first cycle rsp_valid is seen (not yet accepted).
  task automatic do_txn(input int lane, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                        input int busy_cycles,
                        output int t_hs, output int t_start, output int t_rsp, output int n_start,
                        output logic [DW-1:0] dvd_s, output logic [DW-1:0] dvs_s);
    t_hs = -1; t_start = -1; t_rsp = -1; n_start = 0; dvd_s = '0; dvs_s = '0;
    for (int i = 0; i < int'(NR); i++) begin
      req_dividend[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
      req_divisor[i*DW +: DW]  = 32'h0000_0100 + 32'(i);
    end
    req_dividend[lane*DW +: DW] = dvd;
    req_divisor[lane*DW +: DW]  = dvs;
    req_valid = NR'(1) << lane;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (req_ready[lane]) begin
        t_hs = cyc;
        break;
      end
      tick();
    end
    if (t_hs < 0) begin
      check("handshake_wait", 0, 1);
      req_valid = '0;
      return;
    end
    if (busy_cycles > 0) force_busy = 1'b1;
    tick();
    req_valid = '0;
    for (int n = 0; n < 400; n++) begin
      if (force_busy && (cyc >= t_hs + 1 + busy_cycles)) force_busy = 1'b0;
      #1;
      if (div_start) begin
        n_start++;
        if (t_start < 0) begin
          t_start = cyc;
          dvd_s   = div_dividend;
          dvs_s   = div_divisor;
        end
      end
      if (rsp_valid) begin
        t_rsp = cyc;
        break;
      end
      tick();
    end
    force_busy = 1'b0;
    if (t_rsp < 0) check("rsp_wait", 0, 1);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("rsp_drop", 128'(rsp_valid), 0);
  endtask

  typedef struct {
    int          lane;
    logic [31:0] dvd;
    logic [31:0] dvs;
    int          k;
    logic [31:0] q;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t_hs, t_start, t_rsp, n_start;
    logic [DW-1:0] dvd_s, dvs_s;
    int exp_rr[9];
    int n_g;
    int seen_rsp;

    vecs[0] = '{2, 32'd100,        32'd7,          3, 32'd14,         2'b00, 5};
    vecs[1] = '{1, 32'hFFFF_FFCE,  32'd0,          3, 32'd0,          2'b01, 1};
    vecs[2] = '{0, 32'hFFFF_FF9C,  32'd7,          1, 32'hFFFF_FFF2,  2'b00, 3};
    vecs[3] = '{3, 32'h7FFF_FFFF,  32'd1,          5, 32'h7FFF_FFFF,  2'b00, 7};
    vecs[4] = '{2, 32'd9,          32'hFFFF_FFFD,  2, 32'hFFFF_FFFD,  2'b00, 4};
    vecs[5] = '{0, 32'd5,          32'd0,          3, 32'd0,          2'b01, 1};
    exp_rr  = '{0, 1, 3, 0, 1, 3, 0, 3, 0};

    // Reset state
    reset = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    req_valid = '0;
    #1;
    check("reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      fin_k = vecs[i].k;
      do_txn(vecs[i].lane, vecs[i].dvd, vecs[i].dvs, 0, t_hs, t_start, t_rsp, n_start, dvd_s, dvs_s);
      check($sformatf("v%0d_id", i), 128'(rsp_id), 128'(vecs[i].lane));
      check($sformatf("v%0d_quot", i), 128'(rsp_quotient), 128'(vecs[i].q));
      check($sformatf("v%0d_status", i), 128'(rsp_status), 128'(vecs[i].st));
      check($sformatf("v%0d_rsp_lat", i), 128'(t_rsp - t_hs), 128'(vecs[i].lat));
      check($sformatf("v%0d_starts", i), 128'(n_start), (vecs[i].st == 2'b01) ? 0 : 1);
      if (vecs[i].st != 2'b01) begin
        check($sformatf("v%0d_start_lat", i), 128'(t_start - t_hs), 1);
        check($sformatf("v%0d_div_ops", i), {dvd_s, dvs_s}, {vecs[i].dvd, vecs[i].dvs});
      end
      accept();
    end

    // Round robin over lanes 0,1,3; lane 1 drops after six grants
    do_reset();
    fin_k = 1;
    for (int i = 0; i < int'(NR); i++) begin
      req_dividend[i*DW +: DW] = 32'(i + 10);
      req_divisor[i*DW +: DW]  = 32'd1;
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1011;
    #1;
    n_g = 0;
    for (int n = 0; n < 300 && n_g < 9; n++) begin
      if (req_ready != '0) begin
        check($sformatf("rr_grant%0d", n_g), 128'(req_ready), 128'(NR'(1) << exp_rr[n_g]));
        n_g++;
        if (n_g == 6) req_valid = 4'b1001;
        if (n_g == 9) req_valid = '0;
      end
      tick();
    end
    if (n_g < 9) check("rr_grant_count", 128'(n_g), 9);
    req_valid = '0;
    repeat (10) tick();
    rsp_ready = 1'b0;

    // Response backpressure: fields stable, no new grant while lane 1 waits
    fin_k = 3;
    do_txn(0, 32'd20, 32'd4, 0, t_hs, t_start, t_rsp, n_start, dvd_s, dvs_s);
    req_valid = 4'b0010;
    for (int n = 0; n < 10; n++) begin
      tick();
      check($sformatf("bp_hold%0d", n),
            {rsp_valid, rsp_id, rsp_quotient, rsp_status, req_ready},
            {1'b1, 2'd0, 32'd5, 2'b00, 4'b0000});
    end
    req_valid = '0;
    accept();

    // Divider busy for 4 cycles in ISSUE delays a single start pulse
    fin_k = 3;
    do_txn(3, 32'd21, 32'd7, 4, t_hs, t_start, t_rsp, n_start, dvd_s, dvs_s);
    check("busy_start_lat", 128'(t_start - t_hs), 5);
    check("busy_starts", 128'(n_start), 1);
    check("busy_rsp", {rsp_id, rsp_quotient, rsp_status}, {2'd3, 32'd3, 2'b00});
    check("busy_rsp_lat", 128'(t_rsp - t_hs), 9);
    accept();

    // Timeout: divider never finishes
    never_fin = 1'b1;
    do_txn(1, 32'd5, 32'd1, 0, t_hs, t_start, t_rsp, n_start, dvd_s, dvs_s);
    check("to_rsp", {rsp_id, rsp_quotient, rsp_status}, {2'd1, 32'd0, 2'b10});
    check("to_rsp_lat", 128'(t_rsp - t_hs), 10);
    accept();

    // Reset while in WAIT: outputs cleared, no response, rr_ptr back to 0
    req_dividend[2*DW +: DW] = 32'd50;
    req_divisor[2*DW +: DW]  = 32'd5;
    req_valid = 4'b0100;
    #1;
    t_hs = -1;
    for (int n = 0; n < 20; n++) begin
      if (req_ready[2]) begin
        t_hs = cyc;
        break;
      end
      tick();
    end
    if (t_hs < 0) check("rst_handshake_wait", 0, 1);
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_outputs", all_outputs(), 0);
    reset = 1'b0;
    seen_rsp = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (rsp_valid || div_start) seen_rsp++;
    end
    check("rst_no_rsp", 128'(seen_rsp), 0);
    never_fin = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst_rr_ptr", 128'(req_ready), 128'(4'b0001));
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/divide_scheduler.md
Name: divide_scheduler

Overview:
- Shares one `divide` instance (start/busy/fin handshake, signed dividend/divisor/quotient) among NUM_REQ requesters.
- Arbitration is round-robin.
- For each granted request the block latches the operands, pulses the divider's start, waits for fin, and returns the quotient tagged with the requester id.
- It sits between the pipeline stages that need division and the single shared divider, and owns divide-by-zero and hang protection.

Parameters:
- DATA_SIZE, 32, operand/quotient width; must match the shared divider.
- NUM_REQ, 4, number of requesters (>=1).
- ID_W, $clog2(NUM_REQ) (min 1), width of the requester id.
- TIMEOUT, 255, maximum WAIT cycles before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-lane request valid
- req_ready  out  NUM_REQ  per-lane accept, one-hot or zero
- req_dividend  in  NUM_REQ*DATA_SIZE  lane i at [i*DATA_SIZE +: DATA_SIZE], signed
- req_divisor  in  NUM_REQ*DATA_SIZE  same packing, signed
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  lane the response belongs to
- rsp_quotient  out  DATA_SIZE  signed result
- rsp_status  out  2  00 ok, 01 divide-by-zero, 10 timeout
- div_start  out  1  one-cycle start pulse to divider
- div_dividend  out  DATA_SIZE  operand to divider
- div_divisor  out  DATA_SIZE  operand to divider
- div_busy  in  1  divider busy
- div_fin  in  1  divider finished (quotient valid this cycle)
- div_quotient  in  DATA_SIZE  divider result

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset state: IDLE, rr_ptr=0, wait counter=0. All outputs 0: req_ready, rsp_*, div_start, div_dividend, div_divisor.
- Reset mid-operation aborts the transaction silently; no response is issued. The divider shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first lane with req_valid=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally, in IDLE only; all other lanes 0.
  - On handshake: latch dividend, divisor and id; rr_ptr <= (grant+1) mod NUM_REQ.
  - Latched divisor==0: next state is RESP with quotient=0, status=01; the divider is never started.
  - Otherwise: next state is ISSUE.
  - No valid lane: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - div_dividend/div_divisor are driven from the latched registers and held stable through ISSUE and WAIT.
  - If div_busy=1, hold in ISSUE with div_start=0.
  - Else assert div_start=1 for exactly this cycle; clear the wait counter; go to WAIT.
- WAIT:
  - div_start=0.
  - On div_fin=1: capture div_quotient, status=00, go to RESP.
  - Else increment the counter; when it reaches TIMEOUT, go to RESP with quotient=0, status=10.
  - div_fin in any other state is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_quotient and rsp_status are held stable until rsp_ready=1.
  - On handshake go to IDLE; rsp_valid drops the next cycle.
  - rsp_ready without rsp_valid has no effect.
- Latency, with handshake in cycle T and divider not busy:
  - div_start at T+1.
  - If fin arrives k cycles after start, rsp_valid at T+2+k.
  - Divide-by-zero: rsp_valid at T+1.
- Throughput: one transaction in flight; no request is accepted from ISSUE, WAIT or RESP.
- Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
- Arithmetic: no width change; quotient passes through unmodified. Sign, rounding and quantization are owned by the divider.
- Lanes may drop req_valid without a handshake; only a handshaked request is served.

Test Plan:
- Single request: lane 2, dividend=100, divisor=7; divider model (fin 3 cycles after start) returns 14 → div_start at T+1, rsp_valid at T+5, rsp_id=2, rsp_quotient=14, status=00.
- Round robin: lanes 0,1,3 all valid continuously, rsp_ready=1 → grant order 0,1,3,0,1,3. Lane 1 dropping valid mid-sequence → order 0,3,0.
- Divide-by-zero: lane 1, dividend=-50, divisor=0 → no div_start; rsp_valid at T+1, quotient=0, status=01, rsp_id=1.
- Backpressure and busy gating:
  - Hold rsp_ready=0 for 10 cycles → rsp fields stable, req_ready stays 0.
  - Hold div_busy=1 for 4 cycles in ISSUE → div_start is delayed until div_busy falls and pulses once.
- Timeout and reset: TIMEOUT=8, divider never asserts fin → rsp_valid with status=10, quotient=0 after 8 WAIT cycles. Separately, reset asserted in WAIT → next cycle all outputs 0, state IDLE, rr_ptr=0, no response emitted.
